// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: runs the forward expansion to the round-10 key,
// then streams the round keys from 10 down to 0 under a valid/ready handshake.
module aes_inv_key_sched #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         rk_valid,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      REV  = 2'd2
   } state_t;

   // FIPS-197 forward S-box; entry 0x00 sits in the most significant byte
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      sbox = SBOX_TBL[(12'd2047 - {1'b0, b, 3'b000}) -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   state_t         state_r, state_s;
   logic [127:0]   key_r, key_s;
   logic [3:0]     rnd_r, rnd_s;
   logic           valid_r, busy_r, done_r, done_s;

   logic [31:0]    w0_s, w1_s, w2_s, w3_s;
   logic [31:0]    p1_s, p2_s, p3_s;
   logic [31:0]    sw_in_s, t_s;
   logic [3:0]     rc_idx_s;
   logic [127:0]   fwd_key_s, rev_key_s;

   assign w0_s = key_r[127:96];
   assign w1_s = key_r[95:64];
   assign w2_s = key_r[63:32];
   assign w3_s = key_r[31:0];
   assign p3_s = w3_s ^ w2_s;
   assign p2_s = w2_s ^ w1_s;
   assign p1_s = w1_s ^ w0_s;

   // Single SubWord/RotWord datapath shared by both directions
   always_comb begin
      sw_in_s  = w3_s;
      rc_idx_s = rnd_r + 4'd1;
      if (state_r == REV) begin
         sw_in_s  = p3_s;
         rc_idx_s = rnd_r;
      end else begin
         sw_in_s  = w3_s;
         rc_idx_s = rnd_r + 4'd1;
      end
      t_s = sub_word({sw_in_s[23:0], sw_in_s[31:24]}) ^ {rcon(rc_idx_s), 24'h000000};
      fwd_key_s[127:96] = w0_s ^ t_s;
      fwd_key_s[95:64]  = w1_s ^ fwd_key_s[127:96];
      fwd_key_s[63:32]  = w2_s ^ fwd_key_s[95:64];
      fwd_key_s[31:0]   = w3_s ^ fwd_key_s[63:32];
      rev_key_s = {w0_s ^ t_s, p1_s, p2_s, p3_s};
   end

   // Next-state and datapath update
   always_comb begin
      state_s = state_r;
      key_s   = key_r;
      rnd_s   = rnd_r;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               key_s   = key_in;
               rnd_s   = 4'd0;
               state_s = FWD;
            end else begin
               state_s = IDLE;
            end
         end
         FWD: begin
            key_s = fwd_key_s;
            rnd_s = rnd_r + 4'd1;
            if (rnd_r == 4'(NR - 1)) begin
               state_s = REV;
            end else begin
               state_s = FWD;
            end
         end
         REV: begin
            if (rk_ready) begin
               if (rnd_r == 4'd0) begin
                  state_s = IDLE;
                  done_s  = 1'b1;
               end else begin
                  key_s = rev_key_s;
                  rnd_s = rnd_r - 4'd1;
               end
            end else begin
               state_s = REV;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, key and status flags; flags are registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         key_r   <= 128'h0;
         rnd_r   <= 4'd0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         key_r   <= key_s;
         rnd_r   <= rnd_s;
         valid_r <= (state_s == REV);
         busy_r  <= (state_s != IDLE);
         done_r  <= done_s;
      end
   end

   assign rk_out   = key_r;
   assign rk_idx   = rnd_r;
   assign rk_valid = valid_r;
   assign busy     = busy_r;
   assign done     = done_r;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using FIPS-197 round keys.
module tb_aes_inv_key_sched;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [127:0] key_in = 128'h0;
   logic         rk_ready = 1'b0;
   logic [127:0] rk_out;
   logic [3:0]   rk_idx;
   logic         rk_valid;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_fail = 0;
   logic [127:0] fips_rk [0:10];
   logic [127:0] fips_key;

   aes_inv_key_sched #(.NR(10)) dut (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in), .rk_ready(rk_ready),
      .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [127:0] k);
      start  = 1'b1;
      key_in = k;
      tick();
      start  = 1'b0;
      key_in = ~k;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (rk_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({rk_out, rk_idx, rk_valid, busy, done} !== 135'h0) begin
         n_fail++;
         $display("FAIL reset_values: got out=%h idx=%0d v=%b b=%b d=%b, expected all zero",
                  rk_out, rk_idx, rk_valid, busy, done);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy got %b expected 0", busy); end
   endtask

   task automatic test_fips_stream();
      int n;
      rk_ready = 1'b1;
      do_start(fips_key);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL fips_busy: got %b expected 1", busy); end
      wait_valid(n);
      n_checks++;
      if (n != 10) begin n_fail++; $display("FAIL fips_latency: got %0d FWD cycles expected 10", n); end
      for (int i = 10; i >= 0; i--) begin
         n_checks++;
         if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_out !== fips_rk[i]) begin
            n_fail++;
            $display("FAIL fips_rk%0d: got v=%b idx=%0d out=%h expected v=1 idx=%0d out=%h",
                     i, rk_valid, rk_idx, rk_out, i, fips_rk[i]);
         end
         n_checks++;
         if (done !== 1'b0) begin n_fail++; $display("FAIL fips_early_done: got %b expected 0", done); end
         tick();
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fips_done: got d=%b b=%b v=%b expected d=1 b=0 v=0", done, busy, rk_valid);
      end
      tick();
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL fips_done_pulse: got %b expected 0", done); end
      rk_ready = 1'b0;
   endtask

   task automatic test_stall();
      int n;
      int e;
      int cyc;
      logic [15:0] lfsr;
      logic rdy;
      lfsr = 16'hace1;
      rk_ready = 1'b0;
      do_start(fips_key);
      wait_valid(n);
      e = 10;
      cyc = 0;
      while (e >= 0 && cyc < 300) begin
         n_checks++;
         if (rk_valid !== 1'b1 || rk_idx !== 4'(e) || rk_out !== fips_rk[e]) begin
            n_fail++;
            $display("FAIL stall_rk%0d: got v=%b idx=%0d out=%h expected v=1 idx=%0d out=%h",
                     e, rk_valid, rk_idx, rk_out, e, fips_rk[e]);
         end
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         rdy = lfsr[0];
         rk_ready = rdy;
         tick();
         if (rdy) e--;
         cyc++;
      end
      n_checks++;
      if (e != -1 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_done: got remaining=%0d done=%b expected remaining=-1 done=1", e, done);
      end
      rk_ready = 1'b0;
      tick();
   endtask

   task automatic test_zero_key();
      int n;
      rk_ready = 1'b0;
      do_start(128'h0);
      wait_valid(n);
      n_checks++;
      if (rk_idx !== 4'd10 || rk_out !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
         n_fail++;
         $display("FAIL zero_rk10: got idx=%0d out=%h expected idx=10 out=b4ef5bcb3e92e21123e951cf6f8f188e",
                  rk_idx, rk_out);
      end
      rk_ready = 1'b1;
      repeat (9) tick();
      n_checks++;
      if (rk_idx !== 4'd1 || rk_out !== 128'h62636363626363636263636362636363) begin
         n_fail++;
         $display("FAIL zero_rk1: got idx=%0d out=%h expected idx=1 out=62636363626363636263636362636363",
                  rk_idx, rk_out);
      end
      tick();
      n_checks++;
      if (rk_idx !== 4'd0 || rk_out !== 128'h0) begin
         n_fail++;
         $display("FAIL zero_rk0: got idx=%0d out=%h expected idx=0 out=0", rk_idx, rk_out);
      end
      tick();
      tick();
      rk_ready = 1'b0;
   endtask

   task automatic test_start_ignored();
      int n;
      rk_ready = 1'b0;
      do_start(fips_key);
      repeat (3) tick();
      start = 1'b1;
      key_in = 128'h0;
      tick();
      start = 1'b0;
      wait_valid(n);
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      rk_ready = 1'b1;
      for (int i = 10; i >= 0; i--) begin
         n_checks++;
         if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_out !== fips_rk[i]) begin
            n_fail++;
            $display("FAIL ignore_rk%0d: got v=%b idx=%0d out=%h expected v=1 idx=%0d out=%h",
                     i, rk_valid, rk_idx, rk_out, i, fips_rk[i]);
         end
         tick();
      end
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL ignore_done: got %b expected 1", done); end
      rk_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      int n;
      rk_ready = 1'b0;
      do_start(fips_key);
      repeat (4) tick();
      rst = 1'b1;
      start = 1'b1;
      tick();
      n_checks++;
      if ({rk_out, rk_idx, rk_valid, busy, done} !== 135'h0) begin
         n_fail++;
         $display("FAIL rst_fwd: got out=%h idx=%0d v=%b b=%b d=%b expected all zero",
                  rk_out, rk_idx, rk_valid, busy, done);
      end
      rst = 1'b0;
      start = 1'b0;
      do_start(fips_key);
      wait_valid(n);
      rk_ready = 1'b1;
      repeat (6) tick();
      rk_ready = 1'b0;
      n_checks++;
      if (rk_idx !== 4'd4 || rk_out !== fips_rk[4]) begin
         n_fail++;
         $display("FAIL rst_rev_pre: got idx=%0d out=%h expected idx=4 out=%h", rk_idx, rk_out, fips_rk[4]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({rk_out, rk_idx, rk_valid, busy, done} !== 135'h0) begin
         n_fail++;
         $display("FAIL rst_rev: got out=%h idx=%0d v=%b b=%b d=%b expected all zero",
                  rk_out, rk_idx, rk_valid, busy, done);
      end
      do_start(fips_key);
      wait_valid(n);
      n_checks++;
      if (n != 10) begin n_fail++; $display("FAIL rst_restart_latency: got %0d expected 10", n); end
      rk_ready = 1'b1;
      for (int i = 10; i >= 0; i--) begin
         n_checks++;
         if (rk_idx !== 4'(i) || rk_out !== fips_rk[i]) begin
            n_fail++;
            $display("FAIL rst_restart_rk%0d: got idx=%0d out=%h expected out=%h", i, rk_idx, rk_out, fips_rk[i]);
         end
         tick();
      end
      rk_ready = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      int n;
      start = 1'b1;
      key_in = fips_key;
      tick();
      rk_ready = 1'b1;
      wait_valid(n);
      n_checks++;
      if (n != 10) begin n_fail++; $display("FAIL b2b_latency1: got %0d expected 10", n); end
      for (int i = 10; i >= 0; i--) begin
         n_checks++;
         if (rk_valid !== 1'b1 || rk_idx !== 4'(i)) begin
            n_fail++;
            $display("FAIL b2b_idx%0d: got v=%b idx=%0d expected v=1", i, rk_valid, rk_idx);
         end
         tick();
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_done: got d=%b b=%b expected d=1 b=0", done, busy);
      end
      tick();
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_restart: got b=%b d=%b expected b=1 d=0", busy, done);
      end
      wait_valid(n);
      n_checks++;
      if (n != 10 || rk_out !== fips_rk[10]) begin
         n_fail++;
         $display("FAIL b2b_second: got latency=%0d out=%h expected latency=10 out=%h", n, rk_out, fips_rk[10]);
      end
      repeat (12) tick();
      rk_ready = 1'b0;
   endtask

   initial begin
      fips_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips_rk[0]  = fips_key;
      fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      test_reset();
      test_fips_stream();
      test_stall();
      test_zero_key();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
